// File: rtl/wisc_pkg.sv
// Shared WISC-F23 definitions: opcodes, branch condition codes and datapath width.
package wisc_pkg;

    localparam int WISC_DATA_W = 16;

    localparam logic [3:0] OPC_ADD    = 4'b0000;
    localparam logic [3:0] OPC_SUB    = 4'b0001;
    localparam logic [3:0] OPC_XOR    = 4'b0010;
    localparam logic [3:0] OPC_RED    = 4'b0011;
    localparam logic [3:0] OPC_SLL    = 4'b0100;
    localparam logic [3:0] OPC_SRA    = 4'b0101;
    localparam logic [3:0] OPC_ROR    = 4'b0110;
    localparam logic [3:0] OPC_PADDSB = 4'b0111;
    localparam logic [3:0] OPC_LW     = 4'b1000;
    localparam logic [3:0] OPC_SW     = 4'b1001;
    localparam logic [3:0] OPC_LLB    = 4'b1010;
    localparam logic [3:0] OPC_LHB    = 4'b1011;
    localparam logic [3:0] OPC_B      = 4'b1100;
    localparam logic [3:0] OPC_BR     = 4'b1101;
    localparam logic [3:0] OPC_PCS    = 4'b1110;
    localparam logic [3:0] OPC_HLT    = 4'b1111;

    localparam logic [2:0] CC_NE  = 3'b000;
    localparam logic [2:0] CC_EQ  = 3'b001;
    localparam logic [2:0] CC_GT  = 3'b010;
    localparam logic [2:0] CC_LT  = 3'b011;
    localparam logic [2:0] CC_GTE = 3'b100;
    localparam logic [2:0] CC_LTE = 3'b101;
    localparam logic [2:0] CC_OV  = 3'b110;
    localparam logic [2:0] CC_UNC = 3'b111;

endpackage

// File: rtl/flag_reg.sv
// Three-bit flag register with per-bit load enable and async active-high clear.
module flag_reg (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] d,
    input  logic [2:0] en,
    output logic [2:0] q
);

    logic [2:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (en[i]) r_q[i] <= d[i];
            end
        end
    end

    assign q = r_q;

endmodule

// File: rtl/flag_branch_unit.sv
// Latches Z/V/N from committed ALU results and resolves B/BR conditions against the held flags.
module flag_branch_unit
    import wisc_pkg::*;
#(
    parameter int DATA_W = WISC_DATA_W,
    parameter int OPC_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_ovfl,
    input  logic [OPC_W-1:0]  opcode,
    input  logic [2:0]        ccc,
    input  logic              instr_valid,
    output logic              branch_taken,
    output logic              flag_z,
    output logic              flag_v,
    output logic              flag_n
);

    logic       w_upd_all;
    logic       w_upd_z;
    logic       w_is_branch;
    logic       w_cond;
    logic [2:0] w_flag_d;
    logic [2:0] w_flag_en;
    logic [2:0] w_flag_q;

    always_comb begin
        w_upd_all   = 1'b0;
        w_upd_z     = 1'b0;
        w_is_branch = 1'b0;
        case (opcode)
            OPC_W'(OPC_ADD), OPC_W'(OPC_SUB):                   w_upd_all   = 1'b1;
            OPC_W'(OPC_XOR), OPC_W'(OPC_SLL),
            OPC_W'(OPC_SRA), OPC_W'(OPC_ROR):                   w_upd_z     = 1'b1;
            OPC_W'(OPC_B), OPC_W'(OPC_BR):                      w_is_branch = 1'b1;
            default: ;
        endcase
    end

    // Bit order {Z, V, N}
    assign w_flag_d  = {(alu_out == '0), alu_ovfl, alu_out[DATA_W-1]};
    assign w_flag_en = {instr_valid & (w_upd_all | w_upd_z),
                        instr_valid & w_upd_all,
                        instr_valid & w_upd_all};

    flag_reg u_flag_reg (
        .clk (clk),
        .rst (rst),
        .d   (w_flag_d),
        .en  (w_flag_en),
        .q   (w_flag_q)
    );

    assign flag_z = w_flag_q[2];
    assign flag_v = w_flag_q[1];
    assign flag_n = w_flag_q[0];

    always_comb begin
        w_cond = 1'b0;
        case (ccc)
            CC_NE:  w_cond = ~flag_z;
            CC_EQ:  w_cond = flag_z;
            CC_GT:  w_cond = ~flag_z & ~flag_n;
            CC_LT:  w_cond = flag_n;
            CC_GTE: w_cond = flag_z | ~flag_n;
            CC_LTE: w_cond = flag_n | flag_z;
            CC_OV:  w_cond = flag_v;
            CC_UNC: w_cond = 1'b1;
            default: w_cond = 1'b0;
        endcase
    end

    // Flags read here are pre-edge values; branches never load flags.
    assign branch_taken = w_is_branch & w_cond;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed and randomized checks of flag_branch_unit against a behavioural flag/branch model.
module tb_flag_branch_unit;

    logic        clk;
    logic        rst;
    logic [15:0] alu_out;
    logic        alu_ovfl;
    logic [3:0]  opcode;
    logic [2:0]  ccc;
    logic        instr_valid;
    logic        branch_taken;
    logic        flag_z;
    logic        flag_v;
    logic        flag_n;

    int n_checks = 0;
    int n_pass   = 0;

    bit m_z, m_v, m_n;

    flag_branch_unit #(.DATA_W(16), .OPC_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_out      (alu_out),
        .alu_ovfl     (alu_ovfl),
        .opcode       (opcode),
        .ccc          (ccc),
        .instr_valid  (instr_valid),
        .branch_taken (branch_taken),
        .flag_z       (flag_z),
        .flag_v       (flag_v),
        .flag_n       (flag_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic bit model_taken(input logic [3:0] op, input logic [2:0] cc);
        bit cond;
        if (!(op == 4'd12 || op == 4'd13)) return 1'b0;
        case (cc)
            3'd0: cond = !m_z;
            3'd1: cond = m_z;
            3'd2: cond = !m_z && !m_n;
            3'd3: cond = m_n;
            3'd4: cond = m_z || (!m_z && !m_n);
            3'd5: cond = m_n || m_z;
            3'd6: cond = m_v;
            default: cond = 1'b1;
        endcase
        return cond;
    endfunction

    task automatic check_flags(input string tag);
        check({tag, ".flags"}, {29'd0, flag_z, flag_v, flag_n}, {29'd0, m_z, m_v, m_n});
    endtask

    // One instruction: inputs driven after negedge, branch checked before the edge, flags after.
    task automatic step(input logic [3:0] op, input logic [2:0] cc, input logic [15:0] out,
                        input logic ov, input logic vld, input string tag);
        @(negedge clk);
        opcode = op; ccc = cc; alu_out = out; alu_ovfl = ov; instr_valid = vld;
        #1;
        check({tag, ".bt"}, {31'd0, branch_taken}, {31'd0, model_taken(op, cc)});
        @(posedge clk);
        if (vld) begin
            if (op == 4'd0 || op == 4'd1) begin
                m_z = (out == 16'd0); m_v = ov; m_n = out[15];
            end else if (op inside {4'd2, 4'd4, 4'd5, 4'd6}) begin
                m_z = (out == 16'd0);
            end
        end
        #1;
        check_flags(tag);
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        m_z = 0; m_v = 0; m_n = 0;
        check_flags(tag);
        #1 rst = 1'b0;
    endtask

    initial begin
        logic [15:0] r_out;
        logic [3:0]  r_op;
        rst = 1'b1; alu_out = '0; alu_ovfl = 0; opcode = 4'd3; ccc = 0; instr_valid = 0;
        m_z = 0; m_v = 0; m_n = 0;
        #12;
        check_flags("reset");
        rst = 1'b0;

        step(4'd0,  3'd0, 16'h0000, 1'b0, 1'b1, "add_zero");
        step(4'd12, 3'd1, 16'h1234, 1'b1, 1'b1, "b_eq");
        step(4'd1,  3'd0, 16'h8000, 1'b1, 1'b1, "sub_neg_ov");
        step(4'd12, 3'd6, 16'h0000, 1'b0, 1'b1, "b_ov");
        step(4'd12, 3'd3, 16'h0000, 1'b0, 1'b1, "b_lt");
        step(4'd12, 3'd2, 16'h0000, 1'b0, 1'b1, "b_gt");
        step(4'd2,  3'd0, 16'h0000, 1'b0, 1'b1, "xor_zero");
        step(4'd12, 3'd5, 16'h0000, 1'b0, 1'b1, "b_lte");
        step(4'd3,  3'd0, 16'h0000, 1'b0, 1'b1, "red_hold");
        step(4'd7,  3'd0, 16'hFFFF, 1'b1, 1'b1, "paddsb_hold");
        step(4'd0,  3'd0, 16'h0000, 1'b0, 1'b0, "add_invalid");
        async_reset("mid_reset");
        step(4'd13, 3'd1, 16'h0000, 1'b0, 1'b1, "br_eq_post_rst");
        step(4'd13, 3'd0, 16'h0000, 1'b0, 1'b1, "br_ne_post_rst");
        step(4'd2,  3'd7, 16'h0001, 1'b0, 1'b1, "xor_unc");
        step(4'd12, 3'd7, 16'h0000, 1'b0, 1'b1, "b_unc");

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(3))
                0: r_out = 16'h0000;
                1: r_out = 16'h8000;
                2: r_out = 16'hFFFF;
                default: r_out = 16'($urandom);
            endcase
            r_op = ($urandom_range(2) == 0) ? 4'(12 + $urandom_range(1)) : 4'($urandom_range(15));
            if ($urandom_range(60) == 0) async_reset("rnd_reset");
            step(r_op, 3'($urandom_range(7)), r_out, 1'($urandom_range(1)),
                 1'($urandom_range(4) != 0), "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
